// File: rtl/ras_ckpt.sv
// Return address stack with per-branch checkpoint repair.
// Calls push and returns pop at dispatch; a mispredict restores a saved {tosp, cnt, top} snapshot.
module ras_ckpt #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int NCKPT = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int CID_W = $clog2(NCKPT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_en,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop_en,
    input  logic             ckpt_save,
    input  logic [CID_W-1:0] ckpt_save_id,
    input  logic             recover_en,
    input  logic [CID_W-1:0] recover_id,
    input  logic             flush,
    output logic             pred_valid,
    output logic [XLEN-1:0]  pred_addr,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        logic [PTR_W-1:0] tosp;
        logic [CNT_W-1:0] cnt;
        logic [XLEN-1:0]  top;
    } slot_t;

    localparam logic [PTR_W-1:0] TOSP_RST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam slot_t            SLOT_RST = '{tosp: TOSP_RST, cnt: '0, top: '0};

    logic [XLEN-1:0]  stk [DEPTH];
    logic [PTR_W-1:0] tosp;
    logic [CNT_W-1:0] cnt;
    slot_t            slots [NCKPT];

    logic [PTR_W-1:0] tosp_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;
    logic [XLEN-1:0]  top_nxt;
    logic             save_en;
    slot_t            rec_slot;

    assign rec_slot = slots[recover_id];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        tosp_nxt = tosp;
        cnt_nxt  = cnt;
        wr_en    = 1'b0;
        wr_idx   = tosp;
        wr_data  = push_addr;

        if (recover_en) begin
            tosp_nxt = rec_slot.tosp;
            cnt_nxt  = rec_slot.cnt;
            wr_en    = 1'b1;
            wr_idx   = rec_slot.tosp;
            wr_data  = rec_slot.top;
        end else if (push_en && pop_en && cnt != '0) begin
            // Coroutine jalr: replace the top in place, depth unchanged.
            wr_en = 1'b1;
        end else if (push_en) begin
            tosp_nxt = tosp + PTR_W'(1);
            cnt_nxt  = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
            wr_en    = 1'b1;
            wr_idx   = tosp + PTR_W'(1);
        end else if (pop_en && cnt != '0) begin
            tosp_nxt = tosp - PTR_W'(1);
            cnt_nxt  = cnt - CNT_W'(1);
        end

        // Snapshot must see this cycle's write, which the array only shows next cycle.
        top_nxt = (wr_en && wr_idx == tosp_nxt) ? wr_data : stk[tosp_nxt];
        save_en = ckpt_save && !recover_en && !flush;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the stack array is reset too, because pred_addr must read 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            for (int i = 0; i < NCKPT; i++) slots[i] <= SLOT_RST;
            tosp <= TOSP_RST;
            cnt  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NCKPT; i++) slots[i] <= SLOT_RST;
            tosp <= TOSP_RST;
            cnt  <= '0;
        end else begin
            tosp <= tosp_nxt;
            cnt  <= cnt_nxt;
            if (wr_en) stk[wr_idx] <= wr_data;
            if (save_en) slots[ckpt_save_id] <= '{tosp: tosp_nxt, cnt: cnt_nxt, top: top_nxt};
        end
    end

    assign pred_addr  = stk[tosp];
    assign pred_valid = (cnt != '0);
    assign count      = cnt;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed scenarios plus random traffic against an
// integer-indexed stack model with snapshot slots.
module tb_ras_ckpt;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int NCKPT = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CID_W = $clog2(NCKPT);

    logic             clock = 1'b0;
    logic             reset;
    logic             push_en;
    logic [XLEN-1:0]  push_addr;
    logic             pop_en;
    logic             ckpt_save;
    logic [CID_W-1:0] ckpt_save_id;
    logic             recover_en;
    logic [CID_W-1:0] recover_id;
    logic             flush;
    logic             pred_valid;
    logic [XLEN-1:0]  pred_addr;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    ras_ckpt #(.XLEN(XLEN), .DEPTH(DEPTH), .NCKPT(NCKPT)) dut (
        .clock(clock), .reset(reset),
        .push_en(push_en), .push_addr(push_addr), .pop_en(pop_en),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .recover_en(recover_en), .recover_id(recover_id), .flush(flush),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .count(count)
    );

    always #5 clock = ~clock;

    // Reference model: plain integer indices, modulo arithmetic.
    typedef struct {
        int          tosp;
        int          cnt;
        logic [31:0] top;
    } mslot_t;

    logic [31:0] m_stk [DEPTH];
    int          m_tosp;
    int          m_cnt;
    mslot_t      m_slot [NCKPT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear_slots();
        for (int i = 0; i < NCKPT; i++) m_slot[i] = '{tosp: DEPTH - 1, cnt: 0, top: 32'h0};
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_stk[i] = 32'h0;
        m_tosp = DEPTH - 1;
        m_cnt  = 0;
        model_clear_slots();
    endtask

    task automatic model_step(input bit p, input logic [31:0] a, input bit q,
                              input bit sv, input int sid, input bit rc, input int rid, input bit fl);
        if (fl) begin
            m_tosp = DEPTH - 1;
            m_cnt  = 0;
            model_clear_slots();
        end else if (rc) begin
            m_tosp = m_slot[rid].tosp;
            m_cnt  = m_slot[rid].cnt;
            m_stk[m_tosp] = m_slot[rid].top;
        end else begin
            if (p && q && m_cnt > 0) begin
                m_stk[m_tosp] = a;
            end else if (p) begin
                m_tosp = (m_tosp + 1) % DEPTH;
                m_stk[m_tosp] = a;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (q && m_cnt > 0) begin
                m_tosp = (m_tosp + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
            if (sv) m_slot[sid] = '{tosp: m_tosp, cnt: m_cnt, top: m_stk[m_tosp]};
        end
    endtask

    task automatic check_model();
        check("model_valid", 64'(pred_valid), 64'(m_cnt != 0));
        check("model_count", 64'(count), 64'(m_cnt));
        if (m_cnt != 0) check("model_addr", 64'(pred_addr), 64'(m_stk[m_tosp]));
    endtask

    task automatic set_idle();
        push_en = 1'b0; push_addr = '0; pop_en = 1'b0;
        ckpt_save = 1'b0; ckpt_save_id = '0;
        recover_en = 1'b0; recover_id = '0; flush = 1'b0;
    endtask

    task automatic drive(input bit p, input logic [31:0] a, input bit q,
                         input bit sv, input int sid, input bit rc, input int rid, input bit fl);
        push_en = p; push_addr = a; pop_en = q;
        ckpt_save = sv; ckpt_save_id = CID_W'(sid);
        recover_en = rc; recover_id = CID_W'(rid); flush = fl;
        @(posedge clock);
        model_step(p, a, q, sv, sid, rc, rid, fl);
        #1;
        set_idle();
        check_model();
    endtask

    task automatic push(input logic [31:0] a);
        drive(1, a, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pop();
        drive(0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_flush();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        model_reset();
        #1;
        reset = 1'b0;
        check("rst_valid", 64'(pred_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_addr", 64'(pred_addr), 64'd0);

        // Basic push/pop and pop on empty.
        push(32'h100); push(32'h200); push(32'h300);
        check("t1_count3", 64'(count), 64'd3);
        check("t1_addr300", 64'(pred_addr), 64'h300);
        pop();
        check("t1_addr200", 64'(pred_addr), 64'h200);
        check("t1_count2", 64'(count), 64'd2);
        pop(); pop();
        check("t1_empty", 64'(pred_valid), 64'd0);
        pop();
        check("t1_underflow", 64'(count), 64'd0);

        // Overflow wraps and keeps count at DEPTH.
        push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
        check("t2_full", 64'(count), 64'd4);
        check("t2_a50", 64'(pred_addr), 64'h50); pop();
        check("t2_a40", 64'(pred_addr), 64'h40); pop();
        check("t2_a30", 64'(pred_addr), 64'h30); pop();
        check("t2_a20", 64'(pred_addr), 64'h20); pop();
        check("t2_empty", 64'(pred_valid), 64'd0);

        // Simultaneous push and pop replaces the top.
        do_flush();
        push(32'hA0); push(32'hB0);
        push_en = 1'b1; push_addr = 32'hC0; pop_en = 1'b1;
        #1 check("t3_old_top", 64'(pred_addr), 64'hB0);
        drive(1, 32'hC0, 1, 0, 0, 0, 0, 0);
        check("t3_new_top", 64'(pred_addr), 64'hC0);
        check("t3_count", 64'(count), 64'd2);
        pop();
        check("t3_below", 64'(pred_addr), 64'hA0);

        // Recovery repairs an overwritten top entry.
        do_flush();
        push(32'hA0); push(32'hB0);
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        pop(); push(32'hDD); push(32'hEE);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        check("t4_count", 64'(count), 64'd2);
        check("t4_top", 64'(pred_addr), 64'hB0);
        pop();
        check("t4_below", 64'(pred_addr), 64'hA0);

        // Save in a push cycle sees the pushed value; never-saved slot empties.
        do_flush();
        drive(1, 32'h40, 0, 1, 2, 0, 0, 0);
        pop();
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        check("t5_count", 64'(count), 64'd1);
        check("t5_addr", 64'(pred_addr), 64'h40);
        drive(0, 0, 0, 0, 0, 1, 3, 0);
        check("t5_fresh", 64'(pred_valid), 64'd0);

        // Flush outranks recover and push, and clears the slots.
        push(32'h1); push(32'h2);
        drive(1, 32'h3, 0, 1, 0, 0, 0, 0);
        check("t6_count3", 64'(count), 64'd3);
        drive(1, 32'h4, 0, 0, 0, 1, 0, 1);
        check("t6_flush", 64'(count), 64'd0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("t6_slot_clr", 64'(count), 64'd0);
        push(32'h77); push(32'h88);
        do_reset();
        check("t6_rst_addr", 64'(pred_addr), 64'd0);
        check("t6_rst_count", 64'(count), 64'd0);

        // Save and recover the same id: recover wins.
        push(32'h5); drive(0, 0, 0, 1, 1, 0, 0, 0);
        push(32'h6);
        drive(1, 32'h7, 0, 1, 1, 1, 1, 0);
        check("same_id_cnt", 64'(count), 64'd1);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        check("same_id_keep", 64'(pred_addr), 64'h5);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          p, q, sv, rc, fl;
            logic [31:0] a;
            p  = ($urandom_range(0, 99) < 50);
            q  = ($urandom_range(0, 99) < 40);
            sv = ($urandom_range(0, 99) < 30);
            rc = ($urandom_range(0, 99) < 8);
            fl = ($urandom_range(0, 99) < 2);
            a  = $urandom;
            drive(p, a, q, sv, int'($urandom_range(0, NCKPT - 1)),
                  rc, int'($urandom_range(0, NCKPT - 1)), fl);
            if (i == 1500) begin
                do_reset();
                check("rand_rst_addr", 64'(pred_addr), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
